// File: rtl/loba_seq_mult_pkg.sv
// Shared definitions for the sequential LOBA multiplier: accuracy-mode codes,
// FSM states and the per-mode partial-product count.
package loba_pkg;

   localparam logic [1:0] LOBA0 = 2'd0;
   localparam logic [1:0] LOBA1 = 2'd1;
   localparam logic [1:0] LOBA2 = 2'd2;

   typedef enum logic [1:0] {IDLE, SPLIT, ACC, DONE} state_t;

   // Mode 3 deliberately falls into the default and behaves like LOBA2
   function automatic logic [2:0] term_count(input logic [1:0] mode);
      case (mode)
         LOBA0:   return 3'd1;
         LOBA1:   return 3'd3;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/loba_seq_mult_if.sv
// Operand/result handshake bundle for loba_seq_mult.
interface loba_seq_mult_if #(
   parameter int N = 16
) ();
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic [1:0]     mode;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] p;

   modport master (
      output in_valid, a, b, mode, out_ready,
      input  in_ready, out_valid, p
   );

   modport slave (
      input  in_valid, a, b, mode, out_ready,
      output in_ready, out_valid, p
   );
endinterface

// File: rtl/loba_seq_mult_split_seg.sv
// Splits an operand at its leading one into a high and a next-lower W-bit
// segment together with their shift amounts. Purely combinational.
module loba_split_seg #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0]         x,
   output logic [W-1:0]         xh,
   output logic [$clog2(N)-1:0] kh,
   output logic [W-1:0]         xl,
   output logic [$clog2(N)-1:0] kl
);
   localparam int KW = $clog2(N);

   logic [KW-1:0] pos;
   logic [N-1:0]  rem;

   always_comb begin
      pos = '0;
      // Ascending scan: the last set bit seen is the most significant one
      for (int i = 0; i < N; i++) begin
         if (x[i]) pos = KW'(i);
      end
      kh  = (pos >= KW'(W - 1)) ? pos - KW'(W - 1) : '0;
      rem = x & ((N'(1) << kh) - N'(1));
      kl  = (kh >= KW'(W)) ? kh - KW'(W) : '0;
      xh  = W'(x >> kh);
      xl  = W'(rem >> kl);
   end

endmodule

// File: rtl/loba_seq_mult.sv
// Multi-cycle LOBA approximate multiplier: one shifted WxW partial product
// is accumulated per cycle, with the number of terms chosen by the mode.
module loba_seq_mult
   import loba_pkg::*;
#(
   parameter int N = 16,
   parameter int W = 4
) (
   input logic            clk,
   input logic            rst,
   loba_seq_mult_if.slave bus
);
   localparam int KW = $clog2(N);

   state_t          state_reg, state_next;
   logic [1:0]      mode_reg;
   logic [N-1:0]    op_reg [2];
   logic [W-1:0]    seg_h [2];
   logic [W-1:0]    seg_l [2];
   logic [KW-1:0]   k_h [2];
   logic [KW-1:0]   k_l [2];
   logic [W-1:0]    xh_reg [2];
   logic [W-1:0]    xl_reg [2];
   logic [KW-1:0]   kh_reg [2];
   logic [KW-1:0]   kl_reg [2];
   logic [2*N-1:0]  acc_reg;
   logic [2*N-1:0]  p_reg;
   logic [1:0]      cnt_reg;

   logic [W-1:0]    m_a, m_b;
   logic [KW-1:0]   s_a, s_b;
   logic [2*W-1:0]  prod;
   logic [KW:0]     shamt;
   logic [2*N-1:0]  term;
   logic [2*N-1:0]  acc_sum;
   logic            last_term;

   // Index 0 splits operand A, index 1 splits operand B
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_split
         loba_split_seg #(.N(N), .W(W)) u_split (
            .x  (op_reg[gi]),
            .xh (seg_h[gi]),
            .kh (k_h[gi]),
            .xl (seg_l[gi]),
            .kl (k_l[gi])
         );
      end
   endgenerate

   // Counter bit 1 picks A's low segment, bit 0 picks B's: hh, hl, lh, ll
   always_comb begin
      m_a     = cnt_reg[1] ? xl_reg[0] : xh_reg[0];
      s_a     = cnt_reg[1] ? kl_reg[0] : kh_reg[0];
      m_b     = cnt_reg[0] ? xl_reg[1] : xh_reg[1];
      s_b     = cnt_reg[0] ? kl_reg[1] : kh_reg[1];
      prod    = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
      shamt   = {1'b0, s_a} + {1'b0, s_b};
      term    = {{(2*N-2*W){1'b0}}, prod} << shamt;
      acc_sum = acc_reg + term;
   end

   always_comb begin
      state_next = state_reg;
      last_term  = ({1'b0, cnt_reg} == (term_count(mode_reg) - 3'd1));
      case (state_reg)
         IDLE:    if (bus.in_valid) state_next = SPLIT;
         SPLIT:   state_next = ACC;
         ACC:     if (last_term) state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         mode_reg  <= LOBA0;
         acc_reg   <= '0;
         p_reg     <= '0;
         cnt_reg   <= '0;
         for (int i = 0; i < 2; i++) begin
            op_reg[i] <= '0;
            xh_reg[i] <= '0;
            xl_reg[i] <= '0;
            kh_reg[i] <= '0;
            kl_reg[i] <= '0;
         end
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: if (bus.in_valid) begin
               op_reg[0] <= bus.a;
               op_reg[1] <= bus.b;
               mode_reg  <= bus.mode;
            end
            SPLIT: begin
               for (int i = 0; i < 2; i++) begin
                  xh_reg[i] <= seg_h[i];
                  xl_reg[i] <= seg_l[i];
                  kh_reg[i] <= k_h[i];
                  kl_reg[i] <= k_l[i];
               end
               acc_reg <= '0;
               cnt_reg <= '0;
            end
            ACC: begin
               acc_reg <= acc_sum;
               cnt_reg <= cnt_reg + 2'd1;
               // p only ever sees a complete sum
               if (last_term) p_reg <= acc_sum;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.p         = p_reg;

endmodule

// File: tb/tb_loba_seq_mult.sv
// Directed bench for loba_seq_mult (N=16, W=4): hand-computed products,
// latencies, backpressure, back-to-back throughput and mid-operation reset.
module tb_loba_seq_mult;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   loba_seq_mult_if #(.N(16)) bus ();

   loba_seq_mult #(.N(16), .W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Drives one request and returns the product and the number of edges,
   // counting the accepting edge, until out_valid is seen (-1 on timeout).
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m,
                        output logic [31:0] p_o, output int lat);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.mode = m;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.mode = 2'd0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.out_valid) lat = -1;
      p_o = bus.p;
      if (bus.out_valid) begin
         @(negedge clk); bus.out_ready = 1'b1;
         @(posedge clk); #1; bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      n_cmp++; if (bus.p !== 32'h0) begin n_bad++; $display("FAIL reset_p got=%h want=0", bus.p); end
   endtask

   task automatic test_modes();
      logic [15:0] va [6] = '{16'h00FF, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      logic [15:0] vb [6] = '{16'h0003, 16'h0003, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      logic [1:0]  vm [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
      logic [31:0] vp [6] = '{32'h000002D0, 32'h000002FD, 32'hE1000000,
                              32'hFD200000, 32'hFE010000, 32'hFE010000};
      int          vl [6] = '{3, 5, 3, 5, 6, 6};
      logic [31:0] p_o;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         do_op(va[i], vb[i], vm[i], p_o, lat);
         $display("op a=%h b=%h mode=%0d p=%h lat=%0d", va[i], vb[i], vm[i], p_o, lat);
         n_cmp++; if (p_o !== vp[i]) begin n_bad++; $display("FAIL mode_p[%0d] got=%h want=%h", i, p_o, vp[i]); end
         n_cmp++; if (lat != vl[i]) begin n_bad++; $display("FAIL mode_lat[%0d] got=%0d want=%0d", i, lat, vl[i]); end
      end
   endtask

   task automatic test_zero_one();
      logic [31:0] p_o;
      int          lat;
      for (int m = 0; m < 4; m++) begin
         do_op(16'h0000, 16'hFFFF, 2'(m), p_o, lat);
         $display("op a=0000 b=ffff mode=%0d p=%h lat=%0d", m, p_o, lat);
         n_cmp++; if (p_o !== 32'h0 || lat < 0) begin n_bad++; $display("FAIL zero_p[%0d] got=%h lat=%0d want=0", m, p_o, lat); end
      end
      do_op(16'h0001, 16'h0001, 2'd2, p_o, lat);
      $display("op a=0001 b=0001 mode=2 p=%h lat=%0d", p_o, lat);
      n_cmp++; if (p_o !== 32'h1) begin n_bad++; $display("FAIL one_p got=%h want=1", p_o); end
   endtask

   task automatic test_backpressure();
      int lat = 1;
      @(negedge clk);
      bus.a = 16'h00FF; bus.b = 16'h0003; bus.mode = 2'd0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      n_cmp++; if (!bus.out_valid) begin n_bad++; $display("FAIL bp_valid got=%b want=1", bus.out_valid); end
      for (int c = 0; c < 5; c++) begin
         if (c == 1) begin bus.a = 16'h0001; bus.b = 16'h0001; bus.in_valid = 1'b1; end
         if (c == 2) bus.in_valid = 1'b0;
         @(posedge clk); #1;
         n_cmp++; if (bus.p !== 32'h2D0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_hold[%0d] p=%h valid=%b ready=%b want p=2d0 valid=1 ready=0", c, bus.p, bus.out_valid, bus.in_ready);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1 bus.out_ready = 1'b0;
      $display("bp release p=%h in_ready=%b out_valid=%b", bus.p, bus.in_ready, bus.out_valid);
      n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
      n_cmp++; if (bus.p !== 32'h2D0) begin n_bad++; $display("FAIL bp_p_kept got=%h want=2d0", bus.p); end
   endtask

   task automatic test_back_to_back();
      int first = -1;
      int second = -1;
      @(negedge clk);
      bus.a = 16'h00FF; bus.b = 16'h0003; bus.mode = 2'd0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      for (int c = 0; c < 16 && second < 0; c++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            if (first < 0) first = c; else second = c;
         end
      end
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 bus.out_ready = 1'b0;
      $display("b2b first=%0d second=%0d p=%h", first, second, bus.p);
      n_cmp++; if (second < 0 || second - first != 4) begin n_bad++; $display("FAIL b2b_period got=%0d want=4", second - first); end
      n_cmp++; if (bus.p !== 32'h2D0) begin n_bad++; $display("FAIL b2b_p got=%h want=2d0", bus.p); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] p_o;
      int          lat;
      @(negedge clk);
      bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.mode = 2'd2;
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      $display("mid reset p=%h in_ready=%b out_valid=%b", bus.p, bus.in_ready, bus.out_valid);
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_hs valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready); end
      n_cmp++; if (bus.p !== 32'h0) begin n_bad++; $display("FAIL rstmid_p got=%h want=0", bus.p); end
      do_op(16'hFFFF, 16'hFFFF, 2'd2, p_o, lat);
      $display("op a=ffff b=ffff mode=2 p=%h lat=%0d", p_o, lat);
      n_cmp++; if (p_o !== 32'hFE010000) begin n_bad++; $display("FAIL rstmid_after got=%h want=fe010000", p_o); end
      n_cmp++; if (lat != 6) begin n_bad++; $display("FAIL rstmid_lat got=%0d want=6", lat); end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.mode = 2'd0;
      test_reset();
      test_modes();
      test_zero_one();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
